// File: rtl/pipe_reg_elastic.sv
// Elastic pipeline register: DEPTH valid/data stages with a valid/ready handshake on both sides.
// Supports global stall, synchronous flush and a registered occupancy count.
module pipe_reg_elastic #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             stall_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic [OCC_W-1:0] occupancy_o
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic [DEPTH-1:0] rdy_c;

    // Stage k may load when it is empty or everything downstream of it can move.
    always_comb begin : ready_chain
        logic acc;
        rdy_c = '0;
        acc   = out_ready_i;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            acc      = acc | ~valid_q[k];
            rdy_c[k] = acc;
        end
    end

    always_comb begin : next_state
        valid_d = valid_q;
        data_d  = data_q;
        occ_d   = '0;
        if (flush_i) begin
            valid_d = '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                data_d[k] = '0;
            end
        end else if (!stall_i) begin
            if (rdy_c[0]) begin
                valid_d[0] = in_valid_i;
                if (in_valid_i) begin
                    data_d[0] = data_i;
                end
            end
            // Bubbles advance as valid=0 but leave the receiving stage's data untouched.
            for (int unsigned k = 1; k < DEPTH; k++) begin
                if (rdy_c[k]) begin
                    valid_d[k] = valid_q[k-1];
                    if (valid_q[k-1]) begin
                        data_d[k] = data_q[k-1];
                    end
                end
            end
        end
        for (int unsigned k = 0; k < DEPTH; k++) begin
            occ_d = occ_d + OCC_W'(valid_d[k]);
        end
    end

    always_ff @(posedge clk_i) begin : state_reg
        if (rst_i) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    // Handshake outputs are masked so no transfer happens on a stall or flush cycle.
    assign in_ready_o  = rdy_c[0] & ~stall_i & ~flush_i;
    assign out_valid_o = valid_q[DEPTH-1] & ~stall_i & ~flush_i;
    assign data_o      = data_q[DEPTH-1];
    assign occupancy_o = occ_q;

endmodule

// File: doc/pipe_reg_elastic.md
Name: pipe_reg_elastic

Overview:
Parametrised elastic pipeline register: a chain of DEPTH data+valid stages with valid/ready handshake on both sides. It supports global stall, synchronous flush and occupancy reporting. It is the successor to the plain single-stage pipeline register and sits between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) wherever hazard-driven stalls, branch flushes or multi-cycle buffering are needed. Full throughput is one beat per cycle.

Parameters:
WIDTH, 32, payload width in bits (>=1)
DEPTH, 2, number of register stages (>=1)
OCC_W, $clog2(DEPTH+1), width of occupancy_o (derived; not overridden)

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  reset; synchronous, active-high
flush_i  in  1  synchronous clear of all stages (branch/exception squash)
stall_i  in  1  freeze: no stage updates, no transfers in or out
in_valid_i  in  1  upstream beat valid
in_ready_o  out  1  block can accept a beat this cycle
data_i  in  WIDTH  upstream payload
out_valid_o  out  1  output beat valid
out_ready_i  in  1  downstream accepts
data_o  out  WIDTH  output payload (data of stage DEPTH-1)
occupancy_o  out  OCC_W  number of valid stages

Behaviour:
- Reset and polarity: one clock; reset is synchronous and active-high. Ports are named clk_i and rst_i.
- Per-stage state: valid[k] and data[k], k=0 (input side) .. DEPTH-1 (output side).
- Priority per edge: rst_i > flush_i > stall_i > normal operation.
- rst_i=1 at an edge: all valid[k]=0, all data[k]=0.
- Outputs after reset: out_valid_o=0, data_o=0, occupancy_o=0, in_ready_o=1 (if flush_i=0 and stall_i=0).
- Ready chain (combinational):
  - r[DEPTH] = out_ready_i.
  - r[k] = !valid[k] | r[k+1].
- Masked handshake outputs:
  - in_ready_o = r[0] & !stall_i & !flush_i.
  - out_valid_o = valid[DEPTH-1] & !stall_i & !flush_i.
- Transfers:
  - Input transfer = in_valid_i & in_ready_o.
  - Output transfer = out_valid_o & out_ready_i.
- Normal edge (no rst, flush or stall):
  - Stage k>0 loads from k-1 when r[k]=1: valid[k]<=valid[k-1], and data[k]<=data[k-1] only if valid[k-1]=1.
  - Stage 0 loads when r[0]=1: valid[0]<=in_valid_i, and data[0]<=data_i only if in_valid_i=1.
  - Otherwise a stage holds.
  - Data of a stage receiving a bubble is unchanged.
- Stall edge: every valid/data holds. No beat is lost or duplicated. in_valid_i is ignored.
- Flush edge: all valid<=0, all data<=0. The beat presented on in_valid_i that cycle is dropped. No output transfer occurs that cycle.
- Latency: a beat accepted at edge N appears on data_o/out_valid_o in the cycle after edge N+DEPTH-1 when unobstructed. DEPTH=1 means it is visible right after the accepting edge.
- Throughput: 1 beat/cycle sustained with out_ready_i=1. Bubbles in the chain are compressed under backpressure: stages fill from the output side.
- Full (all valid, out_ready_i=0): in_ready_o=0.
- Full with out_ready_i=1: in_ready_o=1, and simultaneous push and pop is allowed; occupancy is unchanged.
- Empty: out_valid_o=0, data_o shows the last retained data[DEPTH-1] value.
- occupancy_o: popcount of valid[]; range 0..DEPTH.
- Payload ordering: strict FIFO; beats are never reordered, duplicated or dropped except by flush/reset.
- Reset or flush mid-stream: all in-flight beats are discarded. in_ready_o=1 in the following cycle (when stall_i=0 and flush_i=0).

Test Plan:
1. Reset then stream: WIDTH=32, DEPTH=3, rst_i high 2 cycles, then push 0x11,0x22,0x33,0x44 back-to-back with out_ready_i=1 -> 0x11 on data_o with out_valid_o=1 in the cycle after the 3rd edge from acceptance; one beat per cycle thereafter, in order.
2. Backpressure fill: out_ready_i=0, push 5 beats -> first 3 accepted, occupancy_o=3, in_ready_o=0. Then raise out_ready_i while pushing 0xAA -> simultaneous pop/push, occupancy_o stays 3, output order 1,2,3,0xAA.
3. Stall: mid-stream with occupancy 2, assert stall_i 4 cycles -> in_ready_o=0, out_valid_o=0, occupancy_o=2, and data_o is unchanged throughout. On release the stream continues with no loss or duplication.
4. Flush with concurrent push: occupancy 3, assert flush_i for 1 cycle while in_valid_i=1 with data 0x55 -> next cycle occupancy_o=0, data_o=0, out_valid_o=0. 0x55 never appears; next push 0x66 emerges after 3 edges.
5. Priority: assert flush_i and stall_i together -> flush wins (all cleared). Assert rst_i with flush_i -> all cleared, and state is identical to plain reset.
6. DEPTH=1 variant: push 0x7 -> out_valid_o=1 the cycle after acceptance. Hold out_ready_i=0 -> in_ready_o=0. Set out_ready_i=1 with a new push -> back-to-back transfer each cycle.
